// File: rtl/red_iterativa_cmp.sv
// Iterative unsigned A > B comparator: right-to-left cell chain with a registered result.
// Define RED_ITERATIVA_EQ_EN to add the registered equality output EQ.
module red_iterativa_cmp #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   output logic         Z
`ifdef RED_ITERATIVA_EQ_EN
   ,
   output logic         EQ
`endif
);

   function automatic logic gt_cell(input logic a, input logic b, input logic g_in);
      return (a & ~b) | (~(a ^ b) & g_in);
   endfunction

   function automatic logic eq_cell(input logic a, input logic b, input logic e_in);
      return e_in & ~(a ^ b);
   endfunction

   logic [N-1:0] g_p0;
   logic         vld_p1;
   logic         z_p1;
`ifdef RED_ITERATIVA_EQ_EN
   logic [N-1:0] e_p0;
   logic         eq_p1;
`endif

   // Stage 0: combinational chain, bit 0 seeds with a "not greater" carry-in
   always_comb begin
      g_p0    = '0;
      g_p0[0] = gt_cell(A[0], B[0], 1'b0);
      for (int i = 1; i < N; i++) begin
         g_p0[i] = gt_cell(A[i], B[i], g_p0[i-1]);
      end
   end

`ifdef RED_ITERATIVA_EQ_EN
   always_comb begin
      e_p0    = '0;
      e_p0[0] = eq_cell(A[0], B[0], 1'b1);
      for (int i = 1; i < N; i++) begin
         e_p0[i] = eq_cell(A[i], B[i], e_p0[i-1]);
      end
   end
`endif

   // Stage 1: result registers load only on valid input, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         z_p1   <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            z_p1 <= g_p0[N-1];
         end
      end
   end

`ifdef RED_ITERATIVA_EQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eq_p1 <= 1'b0;
      end else if (in_valid) begin
         eq_p1 <= e_p0[N-1];
      end
   end

   assign EQ = eq_p1;
`endif

   assign out_valid = vld_p1;
   assign Z         = z_p1;

endmodule

// File: tb/tb_red_iterativa_cmp.sv
// Self-checking bench for red_iterativa_cmp at N=1, N=4 and N=8 (random streaming).
// Honours RED_ITERATIVA_EQ_EN to also check EQ.
module tb_red_iterativa_cmp;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v1, v4, v8;
   logic [0:0] a1, b1;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic       ov1, z1, ov4, z4, ov8, z8;
   logic       eq1, eq4, eq8;
   int         errs = 0;
   int         checks = 0;

   always #5 clk = ~clk;

`ifdef RED_ITERATIVA_EQ_EN
   red_iterativa_cmp #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1),
                                  .out_valid(ov1), .Z(z1), .EQ(eq1));
   red_iterativa_cmp #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4),
                                  .out_valid(ov4), .Z(z4), .EQ(eq4));
   red_iterativa_cmp #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8),
                                  .out_valid(ov8), .Z(z8), .EQ(eq8));
`else
   red_iterativa_cmp #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1),
                                  .out_valid(ov1), .Z(z1));
   red_iterativa_cmp #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4),
                                  .out_valid(ov4), .Z(z4));
   red_iterativa_cmp #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8),
                                  .out_valid(ov8), .Z(z8));
   assign eq1 = 1'b0;
   assign eq4 = 1'b0;
   assign eq8 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_eq(input string tag, input logic got, input logic exp);
`ifdef RED_ITERATIVA_EQ_EN
      check(tag, {31'b0, got}, {31'b0, exp});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ta [4];
      logic [3:0] tb [4];
      logic       ez, eeq, eov;
      int unsigned ra, rb;

      v1 = 0; v4 = 0; v8 = 0;
      a1 = 0; b1 = 0; a4 = 0; b4 = 0; a8 = 0; b8 = 0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_ov1", ov1, 0); check("rst_z1", z1, 0);
      check("rst_ov4", ov4, 0); check("rst_z4", z4, 0);
      check("rst_ov8", ov8, 0); check("rst_z8", z8, 0);
      check_eq("rst_eq4", eq4, 0);
      rst_n = 1;

      // N=1 exhaustive, back-to-back
      for (int i = 0; i < 4; i++) begin
         v1 = 1; a1 = 1'(i >> 1); b1 = 1'(i);
         ez = (a1 > b1); eeq = (a1 == b1);
         @(negedge clk);
         check("n1_ov", ov1, 1);
         check($sformatf("n1_z_%0d%0d", a1, b1), z1, ez);
         check_eq("n1_eq", eq1, eeq);
      end
      v1 = 0; a1 = 'x; b1 = 'x;
      @(negedge clk);
      check("n1_gap_ov", ov1, 0);
      check("n1_gap_hold", z1, 0);

      // N=4 directed: MSB dominance, equality, LSB-only decision
      ta[0] = 4'b1000; tb[0] = 4'b0111;
      ta[1] = 4'b0111; tb[1] = 4'b1000;
      ta[2] = 4'b1010; tb[2] = 4'b1010;
      ta[3] = 4'b0101; tb[3] = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         v4 = 1; a4 = ta[i]; b4 = tb[i];
         ez = (ta[i] > tb[i]); eeq = (ta[i] == tb[i]);
         @(negedge clk);
         check($sformatf("n4_ov_%0d", i), ov4, 1);
         check($sformatf("n4_z_%h_%h", ta[i], tb[i]), z4, ez);
         check_eq($sformatf("n4_eq_%h_%h", ta[i], tb[i]), eq4, eeq);
      end

      // in_valid low with X operands: Z holds 1
      v4 = 0; a4 = 'x; b4 = 'x;
      @(negedge clk);
      check("n4_gap_ov", ov4, 0);
      check("n4_hold_z", z4, 1);

      // async reset mid-cycle with a pending valid input
      v4 = 1; a4 = 4'd7; b4 = 4'd3;
      #2 rst_n = 0;
      #1;
      check("async_z", z4, 0);
      check("async_ov", ov4, 0);
      @(negedge clk);
      rst_n = 1; v4 = 0; a4 = 0; b4 = 0;
      @(negedge clk);
      check("post_rst_ov", ov4, 0);
      check("post_rst_z", z4, 0);

      // N=8 streaming against integer model
      eov = 0; ez = 0; eeq = 0;
      for (int c = 0; c < 1000; c++) begin
         check("s8_ov", ov8, eov);
         check("s8_z", z8, ez);
         check_eq("s8_eq", eq8, eeq);
         ra = $urandom_range(255); rb = $urandom_range(255);
         case (c)
            0: begin ra = 255; rb = 0;   end
            1: begin ra = 0;   rb = 0;   end
            2: begin ra = 170; rb = 170; end
            3: begin ra = 0;   rb = 255; end
            default: ;
         endcase
         v8 = (c < 4) ? 1'b1 : ($urandom_range(9) < 8);
         if (v8) begin
            a8 = 8'(ra); b8 = 8'(rb);
            ez = (ra > rb); eeq = (ra == rb);
         end else begin
            a8 = 'x; b8 = 'x;
         end
         eov = v8;
         @(negedge clk);
      end
      check("s8_ov_last", ov8, eov);
      check("s8_z_last", z8, ez);
      check_eq("s8_eq_last", eq8, eeq);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
